// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the iterative controller.
// Also carries the FIPS-197 reference vectors used by the bench.
package aes_pkg;

  localparam int NR   = 10;
  localparam int RC_W = 4;
  localparam logic [RC_W-1:0] NR_RC = RC_W'(NR);

  typedef logic [127:0]      block_t;
  typedef logic [0:15][7:0]  bytes_t;   // element 0 is bits [127:120]

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // FIPS-197 Appendix B and C.1 vectors.
  localparam block_t KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam block_t KLAST_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam block_t KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t PT_C1    = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t KLAST_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round number 1..10 to its Rcon byte; anything else maps to zero.
  function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
    case (rc)
      RC_W'(1):  return 8'h01;
      RC_W'(2):  return 8'h02;
      RC_W'(3):  return 8'h04;
      RC_W'(4):  return 8'h08;
      RC_W'(5):  return 8'h10;
      RC_W'(6):  return 8'h20;
      RC_W'(7):  return 8'h40;
      RC_W'(8):  return 8'h80;
      RC_W'(9):  return 8'h1b;
      RC_W'(10): return 8'h36;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes128_iter_ctrl_round.sv
// One combinational AES-128 encryption round with on-the-fly key expansion.
// FINAL=1 drops MixColumns for the last round.
module aes128_iter_ctrl_round
  import aes_pkg::*;
#(
  parameter bit FINAL = 1'b0
) (
  input  logic [127:0]    i_state,
  input  logic [127:0]    i_key,
  input  logic [RC_W-1:0] i_rc,
  output logic [127:0]    o_state,
  output logic [127:0]    o_key
);

  bytes_t           w_in;
  bytes_t           w_sb;
  bytes_t           w_sr;
  bytes_t           w_mc;
  logic [0:3][31:0] w_kw;
  logic [0:3][31:0] w_nk;
  logic [31:0]      w_t;

  assign w_in = i_state;
  assign w_kw = i_key;

  genvar g, c, r;
  for (g = 0; g < 16; g++) begin : g_sub
    assign w_sb[g] = sbox(w_in[g]);
  end

  // Byte r+4c is row r of column c; row r rotates left by r columns.
  for (c = 0; c < 4; c++) begin : g_col
    for (r = 0; r < 4; r++) begin : g_row
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    end
    assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                       ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
  end

  assign w_t     = sub_word({w_kw[3][23:0], w_kw[3][31:24]}) ^ {rcon(i_rc), 24'h000000};
  assign w_nk[0] = w_kw[0] ^ w_t;
  assign w_nk[1] = w_kw[1] ^ w_nk[0];
  assign w_nk[2] = w_kw[2] ^ w_nk[1];
  assign w_nk[3] = w_kw[3] ^ w_nk[2];

  assign o_key   = w_nk;
  assign o_state = (FINAL ? w_sr : w_mc) ^ w_nk;

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over shared
// full-round and final-round datapaths, valid/ready on both sides.
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_pt,
  input  logic [127:0]    in_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_ct,
  output logic [127:0]    out_key_last,
  output logic            busy,
  output logic [RC_W-1:0] round_idx
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and data stable until that edge, and ready never
  // depends combinationally on valid.

  state_e          r_state;
  logic [127:0]    r_blk;
  logic [127:0]    r_key;
  logic [RC_W-1:0] r_round;

  state_e          w_state_nx;
  logic [127:0]    w_blk_nx;
  logic [127:0]    w_key_nx;
  logic [RC_W-1:0] w_round_nx;
  logic [127:0]    w_full_blk;
  logic [127:0]    w_full_key;
  logic [127:0]    w_fin_blk;
  logic [127:0]    w_fin_key;

  aes128_iter_ctrl_round #(.FINAL(1'b0)) u_full (
    .i_state (r_blk),
    .i_key   (r_key),
    .i_rc    (r_round),
    .o_state (w_full_blk),
    .o_key   (w_full_key)
  );

  aes128_iter_ctrl_round #(.FINAL(1'b1)) u_final (
    .i_state (r_blk),
    .i_key   (r_key),
    .i_rc    (r_round),
    .o_state (w_fin_blk),
    .o_key   (w_fin_key)
  );

  always_comb begin
    w_state_nx = r_state;
    w_blk_nx   = r_blk;
    w_key_nx   = r_key;
    w_round_nx = r_round;
    case (r_state)
      IDLE: begin
        w_round_nx = '0;
        if (in_valid) begin
          w_blk_nx   = in_pt ^ in_key;
          w_key_nx   = in_key;
          w_round_nx = RC_W'(1);
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (r_round == NR_RC) begin
          w_blk_nx   = w_fin_blk;
          w_key_nx   = w_fin_key;
          w_round_nx = '0;
          w_state_nx = DONE;
        end else if (r_round != '0 && r_round < NR_RC) begin
          w_blk_nx   = w_full_blk;
          w_key_nx   = w_full_key;
          w_round_nx = r_round + 1'b1;
        end else begin
          // Out-of-range round count: abandon the block.
          w_round_nx = '0;
          w_state_nx = IDLE;
        end
      end
      DONE: begin
        w_round_nx = '0;
        if (out_ready) w_state_nx = IDLE;
      end
      default: begin
        w_round_nx = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nx;
      r_blk   <= w_blk_nx;
      r_key   <= w_key_nx;
      r_round <= w_round_nx;
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign busy         = (r_state == RUN) || (r_state == DONE);
  assign out_ct       = out_valid ? r_blk : '0;
  assign out_key_last = out_valid ? r_key : '0;
  assign round_idx    = r_round;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 vectors, back-pressure,
// back-to-back, mid-run reset and idle scenarios.
module tb_aes128_iter_ctrl;
  import aes_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [127:0]    in_pt = '0;
  logic [127:0]    in_key = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [127:0]    out_ct;
  logic [127:0]    out_key_last;
  logic            busy;
  logic [RC_W-1:0] round_idx;

  int n_checks = 0;
  int n_err    = 0;
  logic [127:0] exp_q[$];

  aes128_iter_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pt        (in_pt),
    .in_key       (in_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ct       (out_ct),
    .out_key_last (out_key_last),
    .busy         (busy),
    .round_idx    (round_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counting the accepting edge, out_valid rises on the 11th edge.
  task automatic run_block(input block_t pt, input block_t key, input block_t ct,
                           input block_t klast, input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check({tag, "_round_idx"}, round_idx, k);
      check({tag, "_early_valid"}, out_valid, 1'b0);
      check({tag, "_busy_run"}, busy, 1'b1);
      tick();
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_out_ct"}, out_ct, ct);
    check({tag, "_key_last"}, out_key_last, klast);
    check({tag, "_round_done"}, round_idx, 0);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_after"}, out_valid, 1'b0);
    check({tag, "_ready_after"}, in_ready, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [127:0] exp_c;
    logic acc, hs, found;
    int n_acc, n_hs, h1, a2;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_ct", out_ct, '0);
    check("rst_key_last", out_key_last, '0);
    check("rst_round_idx", round_idx, 0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 App. B and App. C.1
    run_block(PT_B, KEY_B, CT_B, KLAST_B, "appb");
    drain("appb");
    run_block(PT_C1, KEY_C1, CT_C1, KLAST_C1, "appc1");
    drain("appc1");

    // Back-pressure with new inputs offered while DONE
    run_block(PT_C1, KEY_C1, CT_C1, KLAST_C1, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_pt    = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_ct_hold", out_ct, CT_C1);
      check("bp_key_hold", out_key_last, KLAST_C1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp_no_capture", round_idx, 0);

    // Back-to-back with in_valid held high
    exp_q.push_back(CT_B);
    exp_q.push_back(CT_C1);
    in_pt = PT_B; in_key = KEY_B; in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_hs = 0; h1 = -100; a2 = -200;
    for (int cyc = 0; cyc < 80 && n_hs < 2; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("b2b_ct", out_ct, exp_c);
        if (n_hs == 0) h1 = cyc;
        n_hs++;
      end
      if (acc) begin
        if (n_acc == 1) a2 = cyc;
        n_acc++;
      end
      tick();
      if (acc) begin
        if (n_acc == 1) begin in_pt = PT_C1; in_key = KEY_C1; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_handshakes", n_hs, 2);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_accept_gap", a2, h1 + 1);

    // Asynchronous reset at round 5
    in_pt = PT_B; in_key = KEY_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (round_idx == RC_W'(5)) found = 1'b1;
      else tick();
    end
    check("rst_mid_reached_r5", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_round_idx", round_idx, 0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_out_ct", out_ct, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", out_valid, 1'b0);
    run_block(PT_B, KEY_B, CT_B, KLAST_B, "post_rst");
    drain("post_rst");

    // Idle stimulus
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_valid", out_valid, 1'b0);
      check("idle_round", round_idx, 0);
      check("idle_busy", busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
